// File: rtl/lockpick_pkg.sv
// lockpick_pkg: shared types and constants for the lockpick key loader.
package lockpick_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CKSUM  = 3'd2,
      START  = 3'd3,
      STREAM = 3'd4,
      DRAIN  = 3'd5
   } loader_state_t;

   localparam logic [7:0] FRAME_HDR = 8'hA5;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_ERR  = 2'b01;
   localparam logic [1:0] ST_WIN  = 2'b10;
   localparam logic [1:0] ST_LOCK = 2'b11;

   // True for the states in which the host may hand us a byte.
   function automatic logic acceptsHost(input logic [2:0] s);
      return (s == IDLE) || (s == LOAD) || (s == CKSUM);
   endfunction

endpackage

// File: rtl/lockpick_key_loader_if.sv
// lockpick_key_loader_if: byte-wide valid/ready host channel into the loader.
interface lockpick_key_loader_if;
   import lockpick_pkg::*;

   logic       host_valid;
   logic [7:0] host_data;
   logic       host_ready;

   modport master (
      output host_valid,
      output host_data,
      input  host_ready
   );

   modport slave (
      input  host_valid,
      input  host_data,
      output host_ready
   );

endinterface

// File: rtl/lockpick_frame_buf.sv
// lockpick_frame_buf: key byte storage, one synchronous write port and one
// combinational read port. Contents are not reset; a lost frame is simply
// overwritten by the next one.
module lockpick_frame_buf
   import lockpick_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [7:0]        i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [7:0]        o_rd_data
);

   logic [7:0] r_mem [DEPTH];

   // Capture each payload byte at the slot the load index points to.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lockpick_key_loader.sv
// lockpick_key_loader: receives an A5-framed key submission from the host,
// checks its XOR checksum and replays the key bytes to the game as one
// gap-free burst, keeping the host stalled until the game has finished.
// Optional feature: define LOCKPICK_LOADER_TIMEOUT_EN to abandon a frame whose
// host goes quiet for TIMEOUT_CYCLES cycles mid-frame.
module lockpick_key_loader
   import lockpick_pkg::*;
#(
   parameter int KEY_BYTES      = 32,
   parameter int DRAIN_CYCLES   = 34,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   lockpick_key_loader_if.slave host,
   input  logic [1:0]           game_status,
   output logic                 game_start,
   output logic                 game_input_enable,
   output logic [7:0]           game_input_data,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int PAYLOAD = 2 * KEY_BYTES;
   localparam int IDX_W   = $clog2(PAYLOAD);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(PAYLOAD - 1);
   localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_LOAD   = LOAD;
   localparam logic [2:0] S_CKSUM  = CKSUM;
   localparam logic [2:0] S_START  = START;
   localparam logic [2:0] S_STREAM = STREAM;
   localparam logic [2:0] S_DRAIN  = DRAIN;

   if (KEY_BYTES < 1 || DRAIN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("lockpick_key_loader: KEY_BYTES, DRAIN_CYCLES and TIMEOUT_CYCLES must be positive");
   end

   logic [2:0]         r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [7:0]         r_xor;
   logic [IDX_W-1:0]   r_sidx;
   logic [DRAIN_W-1:0] r_drain;

   logic               r_host_ready;
   logic               r_game_start;
   logic               r_enable;
   logic [7:0]         r_data;
   logic               r_frame_err;
   logic               r_busy;

   logic [2:0]         w_next_state;
   logic               w_set_err;
   logic               w_clr_err;
   logic               w_accept;
   logic               w_buf_we;
   logic [IDX_W-1:0]   w_rd_addr;
   logic [7:0]         w_rd_data;

   assign w_accept  = host.host_valid && r_host_ready;
   assign w_buf_we  = (r_state == S_LOAD) && w_accept;
   assign w_rd_addr = (r_state == S_STREAM) ? (r_sidx + IDX_W'(1)) : '0;

   lockpick_frame_buf #(
      .DEPTH  (PAYLOAD),
      .ADDR_W (IDX_W)
   ) u_buf (
      .clk       (clk),
      .i_wr_en   (w_buf_we),
      .i_wr_addr (r_idx),
      .i_wr_data (host.host_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

`ifdef LOCKPICK_LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] LAST_TO = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to;
   logic            w_to_expire;

   assign w_to_expire = ((r_state == S_LOAD) || (r_state == S_CKSUM)) && !w_accept &&
                        (r_to == LAST_TO);

   // Count idle cycles inside a frame; any accepted byte restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to <= '0;
      end else if (((r_state == S_LOAD) || (r_state == S_CKSUM)) && !w_accept) begin
         r_to <= r_to + TO_W'(1);
      end else begin
         r_to <= '0;
      end
   end
`endif

   // Frame sequencing: header hunt, payload load, checksum verdict, burst, drain.
   always_comb begin
      w_next_state = r_state;
      w_set_err    = 1'b0;
      w_clr_err    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && (host.host_data == FRAME_HDR)) begin
               w_next_state = S_LOAD;
               w_clr_err    = 1'b1;
            end
         end
         S_LOAD: begin
            if (w_accept && (r_idx == LAST_IDX)) begin
               w_next_state = S_CKSUM;
            end
         end
         S_CKSUM: begin
            if (w_accept) begin
               if (host.host_data != r_xor) begin
                  w_next_state = S_IDLE;
                  w_set_err    = 1'b1;
               end else if (game_status == ST_ERR) begin
                  w_next_state = S_STREAM;
               end else begin
                  w_next_state = S_START;
               end
            end
         end
         S_START: begin
            w_next_state = S_STREAM;
         end
         S_STREAM: begin
            if (r_sidx == LAST_IDX) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_drain == LAST_DRAIN) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
`ifdef LOCKPICK_LOADER_TIMEOUT_EN
      if (w_to_expire) begin
         w_next_state = S_IDLE;
         w_set_err    = 1'b1;
      end
`endif
   end

   // State register and all outputs, registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_host_ready <= 1'b0;
         r_game_start <= 1'b0;
         r_enable     <= 1'b0;
         r_data       <= '0;
         r_frame_err  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_host_ready <= acceptsHost(w_next_state);
         r_busy       <= (w_next_state != S_IDLE);
         r_game_start <= (w_next_state == S_START);
         r_enable     <= (w_next_state == S_STREAM);
         r_data       <= (w_next_state == S_STREAM) ? w_rd_data : '0;
         if (w_set_err) begin
            r_frame_err <= 1'b1;
         end else if (w_clr_err) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   // Load index and running XOR restart in IDLE and advance per payload byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= '0;
         r_xor <= '0;
      end else if (r_state == S_IDLE) begin
         r_idx <= '0;
         r_xor <= '0;
      end else if (w_buf_we) begin
         r_idx <= r_idx + IDX_W'(1);
         r_xor <= r_xor ^ host.host_data;
      end
   end

   // Stream index tracks the byte on the game bus; drain counter times the game.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sidx  <= '0;
         r_drain <= '0;
      end else begin
         r_sidx  <= (r_state == S_STREAM) ? (r_sidx + IDX_W'(1)) : '0;
         r_drain <= (r_state == S_DRAIN) ? (r_drain + DRAIN_W'(1)) : '0;
      end
   end

   assign host.host_ready   = r_host_ready;
   assign game_start        = r_game_start;
   assign game_input_enable = r_enable;
   assign game_input_data   = r_data;
   assign frame_err         = r_frame_err;
   assign busy              = r_busy;

endmodule

// File: tb/tb_lockpick_key_loader.sv
// tb_lockpick_key_loader: randomized frames against a frame-level reference
// model; expected bursts are queued by the driver and checked by a monitor.
`timescale 1ns/1ps
module tb_lockpick_key_loader;
   import lockpick_pkg::*;

   localparam int KEY_BYTES    = 32;
   localparam int PAYLOAD      = 2 * KEY_BYTES;
   localparam int DRAIN_CYCLES = 34;
`ifdef LOCKPICK_LOADER_TIMEOUT_EN
   localparam int TIMEOUT_CYCLES = 16;
`else
   localparam int TIMEOUT_CYCLES = 65535;
`endif

   typedef struct packed {
      logic                    retry;
      logic [31:0]             acceptEdge;
      logic [PAYLOAD-1:0][7:0] bytes;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] gameStatus = 2'b00;
   logic       gameStart;
   logic       gameEnable;
   logic [7:0] gameData;
   logic       frameErr;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lastAcceptEdge = 0;

   exp_t expQ[$];

   lockpick_key_loader_if hostBus ();

   lockpick_key_loader #(
      .KEY_BYTES      (KEY_BYTES),
      .DRAIN_CYCLES   (DRAIN_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .host              (hostBus),
      .game_status       (gameStatus),
      .game_start        (gameStart),
      .game_input_enable (gameEnable),
      .game_input_data   (gameData),
      .frame_err         (frameErr),
      .busy              (busy)
   );

   // Free-running clock and an edge counter used to time-stamp transfers.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case something upstream fails to terminate.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] xorOf(input logic [PAYLOAD-1:0][7:0] pl);
      logic [7:0] acc = 8'h00;
      for (int i = 0; i < PAYLOAD; i++) acc ^= pl[i];
      return acc;
   endfunction

   // Offer one byte after an optional stall and return once it has transferred.
   task automatic applyStimulus(input logic [7:0] b, input int stall);
      int budget;
      for (int s = 0; s < stall; s++) begin
         hostBus.host_valid = 1'b0;
         @(posedge clk); #1;
      end
      hostBus.host_valid = 1'b1;
      hostBus.host_data  = b;
      budget = 0;
      while (!hostBus.host_ready && budget < 400) begin
         @(posedge clk); #1;
         budget++;
      end
      if (!hostBus.host_ready) begin
         checkOutput("host_ready_wait", {31'd0, hostBus.host_ready}, 32'd1);
         hostBus.host_valid = 1'b0;
         lastAcceptEdge = cyc;
         return;
      end
      @(posedge clk); #1;
      lastAcceptEdge = cyc;
   endtask

   // Send a whole frame; the model decides whether the game should see a burst.
   task automatic sendFrame(input logic [PAYLOAD-1:0][7:0] pl, input logic [7:0] ck,
                            input logic [1:0] status, input int maxStall);
      exp_t e;
      logic good;
      gameStatus = status;
      applyStimulus(FRAME_HDR, $urandom_range(0, maxStall));
      for (int i = 0; i < PAYLOAD; i++) applyStimulus(pl[i], $urandom_range(0, maxStall));
      applyStimulus(ck, $urandom_range(0, maxStall));
      hostBus.host_valid = 1'b0;
      good = (ck == xorOf(pl));
      if (good) begin
         e.retry      = (status == ST_ERR);
         e.acceptEdge = lastAcceptEdge;
         e.bytes      = pl;
         expQ.push_back(e);
         checkOutput("frame_err_after_good", {31'd0, frameErr}, 32'd0);
      end else begin
         checkOutput("frame_err_after_bad", {31'd0, frameErr}, 32'd1);
         checkOutput("host_ready_after_bad", {31'd0, hostBus.host_ready}, 32'd1);
         checkOutput("busy_after_bad", {31'd0, busy}, 32'd0);
      end
   endtask

   // Wait for the loader to return to the host after a burst.
   task automatic waitForIdle();
      int budget = 0;
      while (!(hostBus.host_ready && !busy) && budget < 400) begin
         @(posedge clk); #1;
         budget++;
      end
      checkOutput("returned_to_idle", {31'd0, hostBus.host_ready}, 32'd1);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   // Monitor: pops the expected frame at each burst and checks timing and data.
   exp_t cur;
   logic inBurst = 1'b0;
   logic startSeen = 1'b0;
   logic prevStart = 1'b0;
   logic countingDrain = 1'b0;
   int   k = 0;
   int   drainCnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         inBurst       = 1'b0;
         startSeen     = 1'b0;
         countingDrain = 1'b0;
      end else begin
         prevStart = startSeen;
         startSeen = 1'b0;
         if (gameStart) begin
            startSeen = 1'b1;
            if (expQ.size() == 0) begin
               checkOutput("unexpected_start", {31'd0, gameStart}, 32'd0);
            end else begin
               checkOutput("start_on_retry", {31'd0, expQ[0].retry}, 32'd0);
               checkOutput("start_cycle", cyc, expQ[0].acceptEdge);
            end
         end
         if (gameEnable) begin
            if (!inBurst) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_enable", {31'd0, gameEnable}, 32'd0);
               end else begin
                  cur     = expQ.pop_front();
                  inBurst = 1'b1;
                  k       = 0;
                  checkOutput("first_enable_cycle", cyc,
                              cur.acceptEdge + (cur.retry ? 32'd0 : 32'd1));
                  checkOutput("start_before_burst", {31'd0, prevStart}, {31'd0, !cur.retry});
               end
            end
            if (inBurst) begin
               if (k < PAYLOAD) begin
                  checkOutput($sformatf("burst_byte_%0d", k), {24'd0, gameData}, {24'd0, cur.bytes[k]});
               end
               k++;
            end
         end else if (inBurst) begin
            inBurst = 1'b0;
            checkOutput("burst_length", k, PAYLOAD);
            countingDrain = 1'b1;
            drainCnt      = 0;
         end
         if (countingDrain) begin
            if (!hostBus.host_ready) begin
               drainCnt++;
               if (drainCnt > 500) begin
                  checkOutput("drain_cycles", drainCnt, DRAIN_CYCLES);
                  countingDrain = 1'b0;
               end
            end else begin
               checkOutput("drain_cycles", drainCnt, DRAIN_CYCLES);
               countingDrain = 1'b0;
            end
         end
      end
   end

   // Directed and randomized frame sequence.
   initial begin
      logic [PAYLOAD-1:0][7:0] pl;
      logic [7:0]              ck;
      int                      budget;

      hostBus.host_valid = 1'b0;
      hostBus.host_data  = 8'h00;

      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("reset_host_ready", {31'd0, hostBus.host_ready}, 32'd0);
      checkOutput("reset_game_start", {31'd0, gameStart}, 32'd0);
      checkOutput("reset_enable", {31'd0, gameEnable}, 32'd0);
      checkOutput("reset_data", {24'd0, gameData}, 32'd0);
      checkOutput("reset_frame_err", {31'd0, frameErr}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready_after_reset", {31'd0, hostBus.host_ready}, 32'd1);

      // Counting payload with its correct checksum, fresh game.
      for (int i = 0; i < PAYLOAD; i++) pl[i] = 8'(i);
      sendFrame(pl, 8'h00, ST_IDLE, 0);
      waitForIdle();

      // Same payload, wrong checksum.
      sendFrame(pl, 8'h01, ST_IDLE, 0);
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("no_burst_after_bad", {31'd0, busy}, 32'd0);

      // Junk ahead of the header is dropped.
      applyStimulus(8'h12, 0);
      applyStimulus(8'h34, 0);
      hostBus.host_valid = 1'b0;
      checkOutput("preamble_ignored", {31'd0, busy}, 32'd0);
      for (int i = 0; i < PAYLOAD; i++) pl[i] = 8'($urandom);
      sendFrame(pl, xorOf(pl), ST_IDLE, 0);
      waitForIdle();

      // Game already waiting for input: no start pulse.
      for (int i = 0; i < PAYLOAD; i++) pl[i] = 8'($urandom);
      sendFrame(pl, xorOf(pl), ST_ERR, 0);
      waitForIdle();

      // Random frames with host stalls, random game status, occasional corruption.
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < PAYLOAD; i++) pl[i] = 8'($urandom);
         ck = xorOf(pl);
         if ($urandom_range(0, 3) == 0) ck ^= 8'(1 << $urandom_range(0, 7));
         sendFrame(pl, ck, 2'($urandom_range(0, 3)), 5);
         waitForIdle();
      end

      // Reset during burst cycle 20; that frame is lost.
      for (int i = 0; i < PAYLOAD; i++) pl[i] = 8'($urandom);
      sendFrame(pl, xorOf(pl), ST_IDLE, 0);
      budget = 0;
      while (!gameEnable && budget < 50) begin
         @(posedge clk); #1;
         budget++;
      end
      checkOutput("burst_began", {31'd0, gameEnable}, 32'd1);
      repeat (19) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("midreset_enable", {31'd0, gameEnable}, 32'd0);
      checkOutput("midreset_start", {31'd0, gameStart}, 32'd0);
      checkOutput("midreset_data", {24'd0, gameData}, 32'd0);
      checkOutput("midreset_ready", {31'd0, hostBus.host_ready}, 32'd0);
      checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset_frame_err", {31'd0, frameErr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < PAYLOAD; i++) pl[i] = 8'($urandom);
      sendFrame(pl, xorOf(pl), ST_IDLE, 2);
      waitForIdle();

`ifdef LOCKPICK_LOADER_TIMEOUT_EN
      // Host goes silent after ten payload bytes.
      applyStimulus(FRAME_HDR, 0);
      for (int i = 0; i < 10; i++) applyStimulus(8'($urandom), 0);
      hostBus.host_valid = 1'b0;
      repeat (TIMEOUT_CYCLES - 1) begin @(posedge clk); #1; end
      checkOutput("timeout_not_yet", {31'd0, frameErr}, 32'd0);
      checkOutput("timeout_still_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      checkOutput("timeout_frame_err", {31'd0, frameErr}, 32'd1);
      checkOutput("timeout_idle", {31'd0, busy}, 32'd0);
      checkOutput("timeout_ready", {31'd0, hostBus.host_ready}, 32'd1);
      for (int i = 0; i < PAYLOAD; i++) pl[i] = 8'($urandom);
      sendFrame(pl, xorOf(pl), ST_IDLE, 3);
      waitForIdle();
`endif

      checkOutput("scoreboard_empty", expQ.size(), 32'd0);
      checkOutput("burst_closed", {31'd0, inBurst}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
